// File: rtl/display_pkg.sv
// Shared definitions for the serial display chain: frame geometry and the
// frame arbiter state encoding.
package display_pkg;

  localparam int DIGITS      = 6;
  localparam int SEG_BITS    = 8;
  localparam int SHIFT_WIDTH = DIGITS * SEG_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/serial_frame_arbiter_if.sv
// Frame-source side of the serial display chain arbiter: two request/frame
// pairs, their grants, status, and the serial data/latch pins.
interface serial_frame_arbiter_if #(
  parameter int FRAME_W = display_pkg::SHIFT_WIDTH
);

  logic               i_en;
  logic               i_req0;
  logic [FRAME_W-1:0] i_frame0;
  logic               i_req1;
  logic [FRAME_W-1:0] i_frame1;
  logic               o_grant0;
  logic               o_grant1;
  logic               o_busy;
  logic               o_done;
  logic               o_serial_data;
  logic               o_serial_latch;

  // The arbiter itself.
  modport slave (
    input  i_en, i_req0, i_frame0, i_req1, i_frame1,
    output o_grant0, o_grant1, o_busy, o_done, o_serial_data, o_serial_latch
  );

  // The formatters and pin-side observers.
  modport master (
    output i_en, i_req0, i_frame0, i_req1, i_frame1,
    input  o_grant0, o_grant1, o_busy, o_done, o_serial_data, o_serial_latch
  );

endinterface

// File: rtl/serial_frame_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the requester
// that did not win last time gets the chain.
module rr_arbiter2 (
  input  logic req0,
  input  logic req1,
  input  logic rr_last,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = req1 & (~req0 | ~rr_last);

endmodule

// File: rtl/serial_frame_arbiter.sv
// Shares the 48-bit shift-then-latch display chain between two frame sources:
// round-robin grant, MSB-first shift, one negedge latch strobe, then a short gap.
module serial_frame_arbiter #(
  parameter int SHIFT_WIDTH = display_pkg::SHIFT_WIDTH,
  parameter int IDLE_GAP    = 2
) (
  input logic                   o_serial_clk,
  input logic                   i_reset_n,
  serial_frame_arbiter_if.slave bus
);

  import display_pkg::*;

  localparam int                CNT_W    = $clog2(SHIFT_WIDTH + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SHIFT_WIDTH - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD = CNT_W'(IDLE_GAP);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [SHIFT_WIDTH-1:0] shreg_reg, shreg_next;
  logic                   data_reg, data_next;
  logic                   rr_last_reg, rr_last_next;
  logic                   grant0_reg, grant0_next;
  logic                   grant1_reg, grant1_next;
  logic                   done_reg, done_next;
  logic                   latch_req_reg, latch_req_next;
  logic                   latch_reg;

  logic                   arb_valid;
  logic                   arb_winner;
  logic [SHIFT_WIDTH-1:0] sel_frame;

  rr_arbiter2 u_rr_arbiter2 (
    .req0    (bus.i_req0),
    .req1    (bus.i_req1),
    .rr_last (rr_last_reg),
    .valid   (arb_valid),
    .winner  (arb_winner)
  );

  assign sel_frame = arb_winner ? bus.i_frame1 : bus.i_frame0;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    shreg_next     = shreg_reg;
    data_next      = 1'b0;
    rr_last_next   = rr_last_reg;
    grant0_next    = 1'b0;
    grant1_next    = 1'b0;
    done_next      = 1'b0;
    latch_req_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.i_en && arb_valid) begin
          // MSB goes out on the grant edge; the rest waits in shreg.
          data_next    = sel_frame[SHIFT_WIDTH-1];
          shreg_next   = {sel_frame[SHIFT_WIDTH-2:0], 1'b0};
          grant0_next  = ~arb_winner;
          grant1_next  = arb_winner;
          rr_last_next = arb_winner;
          cnt_next     = CNT_LOAD;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_reg == '0) begin
          latch_req_next = 1'b1;
          state_next     = LATCH;
        end else begin
          data_next  = shreg_reg[SHIFT_WIDTH-1];
          shreg_next = shreg_reg << 1;
          cnt_next   = cnt_reg - CNT_ONE;
        end
      end
      LATCH: begin
        done_next = 1'b1;
        if (IDLE_GAP == 0) begin
          state_next = IDLE;
        end else begin
          cnt_next   = GAP_LOAD;
          state_next = GAP;
        end
      end
      GAP: begin
        if (cnt_reg <= CNT_ONE) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge o_serial_clk) begin
    if (!i_reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      shreg_reg     <= '0;
      data_reg      <= 1'b0;
      rr_last_reg   <= 1'b1;
      grant0_reg    <= 1'b0;
      grant1_reg    <= 1'b0;
      done_reg      <= 1'b0;
      latch_req_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shreg_reg     <= shreg_next;
      data_reg      <= data_next;
      rr_last_reg   <= rr_last_next;
      grant0_reg    <= grant0_next;
      grant1_reg    <= grant1_next;
      done_reg      <= done_next;
      latch_req_reg <= latch_req_next;
    end
  end

  // Retiming the strobe onto the falling edge keeps both latch edges half a
  // cycle away from the chain's shift edge.
  always_ff @(negedge o_serial_clk) begin
    if (!i_reset_n) begin
      latch_reg <= 1'b0;
    end else begin
      latch_reg <= latch_req_reg;
    end
  end

  assign bus.o_grant0       = grant0_reg;
  assign bus.o_grant1       = grant1_reg;
  assign bus.o_busy         = (state_reg != IDLE);
  assign bus.o_done         = done_reg;
  assign bus.o_serial_data  = data_reg;
  assign bus.o_serial_latch = latch_reg;

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Bench for serial_frame_arbiter: a model chain (posedge shift + latch-edge
// parallel register) checked against a scoreboard of granted frames.
module tb_serial_frame_arbiter;

  localparam int W = 48;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  int   latch_count = 0;

  logic [W-1:0] chain_reg;
  logic [W-1:0] par_reg;
  logic [W-1:0] sb_q[$];

  serial_frame_arbiter_if #(.FRAME_W(W)) bus ();

  serial_frame_arbiter #(.SHIFT_WIDTH(W), .IDLE_GAP(2)) dut (
    .o_serial_clk (clk),
    .i_reset_n    (rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic note_fail(input string name);
    total++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // Downstream chain model.
  always @(posedge clk) chain_reg <= {chain_reg[W-2:0], bus.o_serial_data};

  always @(posedge bus.o_serial_latch) begin
    logic [W-1:0] exp;
    par_reg     <= chain_reg;
    latch_count <= latch_count + 1;
    check("latch_rise_clk_low", {47'd0, clk}, 48'd0);
    if (sb_q.size() == 0) begin
      note_fail("unexpected_latch");
    end else begin
      exp = sb_q.pop_front();
      check("latched_frame", chain_reg, exp);
    end
    $display("latch #%0d at cycle %0d value %h", latch_count + 1, cyc, chain_reg);
  end

  always @(negedge bus.o_serial_latch)
    if (rst_n === 1'b1) check("latch_fall_clk_low", {47'd0, clk}, 48'd0);

  task automatic wait_grant(input int budget, output int who, output int at_cyc);
    who    = -1;
    at_cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.o_grant0 || bus.o_grant1) begin
        who    = bus.o_grant1 ? 1 : 0;
        at_cyc = cyc;
        break;
      end
    end
    if (who < 0) note_fail("grant_timeout");
    else $display("grant%0d at cycle %0d", who, at_cyc);
  endtask

  task automatic wait_done(input int budget, output int at_cyc);
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.o_done) begin
        at_cyc = cyc;
        break;
      end
    end
    if (at_cyc < 0) note_fail("done_timeout");
  endtask

  task automatic wait_idle(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.o_busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) note_fail("idle_timeout");
  endtask

  typedef struct {
    logic         req0;
    logic         req1;
    logic [W-1:0] frame0;
    logic [W-1:0] frame1;
    int           exp_grant;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int who, gc, dc, prev_gc, mark, grants_seen, lc_before;
    logic [W-1:0] exp_frame, par_before, frame_a, frame_b;

    watchdog_start();

    rst_n          = 1'b0;
    bus.i_en       = 1'b0;
    bus.i_req0     = 1'b0;
    bus.i_req1     = 1'b0;
    bus.i_frame0   = '0;
    bus.i_frame1   = '0;

    // rr_last resets to 1, so requester 0 wins the first tie.
    vecs[0] = '{1'b1, 1'b0, 48'h0123_4567_89AB, 48'h0,              0};
    vecs[1] = '{1'b1, 1'b1, 48'hA5A5_A5A5_A5A5, 48'h5A5A_5A5A_5A5A, 1};
    vecs[2] = '{1'b1, 1'b1, 48'hDEAD_BEEF_CAFE, 48'h1234_5678_9ABC, 0};
    vecs[3] = '{1'b1, 1'b1, 48'h1111_1111_1111, 48'h8000_0000_0001, 1};
    vecs[4] = '{1'b0, 1'b1, 48'h0,              48'hFEDC_BA98_7654, 1};
    vecs[5] = '{1'b1, 1'b0, 48'h0000_0000_0001, 48'h0,              0};
    vecs[6] = '{1'b1, 1'b0, 48'hFFFF_FFFF_FFFF, 48'h0,              0};
    vecs[7] = '{1'b0, 1'b1, 48'h0,              48'h0000_0000_0000, 1};

    repeat (3) @(negedge clk);
    check("reset_data",  {47'd0, bus.o_serial_data},  48'd0);
    check("reset_latch", {47'd0, bus.o_serial_latch}, 48'd0);
    check("reset_grant", {46'd0, bus.o_grant1, bus.o_grant0}, 48'd0);
    check("reset_busy",  {47'd0, bus.o_busy}, 48'd0);
    check("reset_done",  {47'd0, bus.o_done}, 48'd0);
    rst_n    = 1'b1;
    bus.i_en = 1'b1;
    @(negedge clk);

    // Table-driven single frames.
    for (int i = 0; i < 8; i++) begin
      bus.i_req0   = vecs[i].req0;
      bus.i_req1   = vecs[i].req1;
      bus.i_frame0 = vecs[i].frame0;
      bus.i_frame1 = vecs[i].frame1;
      wait_grant(4, who, gc);
      check("tbl_grant", W'(who), W'(vecs[i].exp_grant));
      check("tbl_busy", {47'd0, bus.o_busy}, 48'd1);
      exp_frame = vecs[i].exp_grant ? vecs[i].frame1 : vecs[i].frame0;
      if (who >= 0) sb_q.push_back(who == 1 ? vecs[i].frame1 : vecs[i].frame0);
      bus.i_req0 = 1'b0;
      bus.i_req1 = 1'b0;
      wait_done(60, dc);
      check("tbl_done_latency", W'(dc - gc), W'(49));
      check("tbl_parallel", par_reg, exp_frame);
      wait_idle(10);
    end

    // Both requesters held: alternating grants at the minimum frame period.
    frame_a = 48'hAAAA_0000_5555;
    frame_b = 48'h3C3C_C3C3_0F0F;
    bus.i_frame0 = frame_a;
    bus.i_frame1 = frame_b;
    bus.i_req0   = 1'b1;
    bus.i_req1   = 1'b1;
    prev_gc = 0;
    for (int i = 0; i < 4; i++) begin
      wait_grant(60, who, gc);
      check("rr_alternate", W'(who), W'(i % 2));
      if (i > 0) check("rr_period", W'(gc - prev_gc), W'(52));
      if (who >= 0) sb_q.push_back(who == 1 ? frame_b : frame_a);
      prev_gc = gc;
    end
    bus.i_req0 = 1'b0;
    bus.i_req1 = 1'b0;
    wait_done(60, dc);
    check("rr_last_parallel", par_reg, frame_b);
    wait_idle(10);

    // Frame change after grant must not reach the chain.
    bus.i_req1   = 1'b1;
    bus.i_frame1 = 48'h0F0F_F0F0_1234;
    wait_grant(4, who, gc);
    check("hold_grant", W'(who), W'(1));
    sb_q.push_back(48'h0F0F_F0F0_1234);
    @(negedge clk);
    bus.i_frame1 = 48'hBEEF_BEEF_BEEF;
    bus.i_req1   = 1'b0;
    wait_done(60, dc);
    check("hold_parallel", par_reg, 48'h0F0F_F0F0_1234);
    wait_idle(10);

    // Enable dropped mid-frame: frame finishes, no new grant until re-enabled.
    bus.i_req0   = 1'b1;
    bus.i_frame0 = 48'h5555_AAAA_6789;
    wait_grant(4, who, gc);
    check("en_grant", W'(who), W'(0));
    sb_q.push_back(48'h5555_AAAA_6789);
    while (cyc < gc + 9) @(negedge clk);
    bus.i_en = 1'b0;
    wait_done(60, dc);
    check("en_done_latency", W'(dc - gc), W'(49));
    check("en_parallel", par_reg, 48'h5555_AAAA_6789);
    grants_seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (bus.o_grant0 || bus.o_grant1) grants_seen++;
    end
    check("en_low_no_grant", W'(grants_seen), 48'd0);
    bus.i_en = 1'b1;
    mark = cyc;
    wait_grant(3, who, gc);
    check("en_regrant_latency", W'(gc - mark), W'(1));
    sb_q.push_back(48'h5555_AAAA_6789);
    bus.i_req0 = 1'b0;
    wait_done(60, dc);
    wait_idle(10);

    // Reset mid-frame: no latch, parallel register untouched, clean restart.
    par_before   = par_reg;
    lc_before    = latch_count;
    bus.i_req0   = 1'b1;
    bus.i_frame0 = 48'h0BAD_F00D_0BAD;
    wait_grant(4, who, gc);
    bus.i_req0 = 1'b0;
    while (cyc < gc + 19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_busy",  {47'd0, bus.o_busy}, 48'd0);
    check("rst_data",  {47'd0, bus.o_serial_data}, 48'd0);
    check("rst_latch", {47'd0, bus.o_serial_latch}, 48'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("rst_no_latch", W'(latch_count - lc_before), 48'd0);
    check("rst_parallel_kept", par_reg, par_before);
    bus.i_req0   = 1'b1;
    bus.i_req1   = 1'b1;
    bus.i_frame0 = 48'h0246_8ACE_1357;
    bus.i_frame1 = 48'h9999_9999_9999;
    wait_grant(4, who, gc);
    check("rst_rr_reset", W'(who), W'(0));
    if (who >= 0) sb_q.push_back(who == 1 ? 48'h9999_9999_9999 : 48'h0246_8ACE_1357);
    bus.i_req0 = 1'b0;
    bus.i_req1 = 1'b0;
    wait_done(60, dc);
    check("rst_done_latency", W'(dc - gc), W'(49));
    check("rst_clean_frame", par_reg, 48'h0246_8ACE_1357);
    wait_idle(10);

    check("sb_empty", W'(sb_q.size()), 48'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  task automatic watchdog_start();
    fork
      begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
      end
    join_none
  endtask

endmodule
